led_sel_ctrl: RTL
=================

LED_SEL_CTRL -- requirements
Module: led_sel_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 16'd50000: cycles a raw button level must stay stable before it is accepted.
REQ-002 Parameter SCAN_CYCLES, default 26'd50000000: cycles between auto-scan steps.
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port btn_raw  input  1  undebounced step push-button, active-high, asynchronous to clk.
REQ-006 Port auto_en  input  1  1 = auto-scan mode, 0 = manual step mode.
REQ-007 Port cap_en  input  1  single-cycle strobe that captures the display sources.
REQ-008 Port alu_a  input  32  first display source word.
REQ-009 Port alu_b  input  32  second display source word.
REQ-010 Port of_in  input  1  overflow flag source.
REQ-011 Port zf_in  input  1  zero flag source.
REQ-012 Port dina  output  32  captured alu_a, fed to the LED byte mux.
REQ-013 Port dinb  output  32  captured alu_b.
REQ-014 Port ofa  output  1  captured of_in.
REQ-015 Port zfa  output  1  captured zf_in.
REQ-016 Port sela  output  3  byte select for the LED mux.
REQ-017 Port step_pulse  output  1  one-cycle pulse each time sela advances.

Function
REQ-018 btn_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-019 The debouncer SHALL be a 4-state FSM: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-020 IDLE -> PRESS_WAIT when the synced button = 1; the debounce counter clears on entry.
REQ-021 PRESS_WAIT -> HELD after DB_CYCLES consecutive cycles of synced 1; any 0 returns to IDLE.
REQ-022 PRESS_WAIT -> HELD SHALL raise an internal press event for exactly one cycle.
REQ-023 HELD -> RELEASE_WAIT on synced 0; RELEASE_WAIT -> IDLE after DB_CYCLES consecutive 0s; any 1 returns to HELD.
REQ-024 Holding the button SHALL produce exactly one press event.
REQ-025 Manual mode (auto_en=0): each press event advances sela by 1.
REQ-026 Auto mode (auto_en=1): a scan counter counts 0..SCAN_CYCLES-1; sela advances on wrap.
REQ-027 In auto mode, press events SHALL be ignored.
REQ-028 The scan counter SHALL clear whenever auto_en=0, so the first auto step occurs SCAN_CYCLES cycles after auto_en rises.
REQ-029 sela SHALL wrap 3'd7 -> 3'd0; step_pulse SHALL assert in the same cycle sela updates.
REQ-030 When cap_en=1, dina/dinb/ofa/zfa SHALL load the sources on that edge; otherwise they hold.
REQ-031 Capture SHALL be independent of stepping; a simultaneous cap_en and step both take effect.
REQ-032 Outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-033 When rst_n=0 at a clk edge, the following SHALL clear to 0: sela, step_pulse, dina, dinb, ofa, zfa, the debounce and scan counters, and the synchronizer flops; the FSM returns to IDLE.
REQ-034 Reset SHALL take priority over cap_en, a press event, and scan wrap in the same cycle.
REQ-035 Reset asserted mid-debounce or mid-scan SHALL discard the partial count; no step SHALL occur on release of reset.

Verification (DB_CYCLES=4, SCAN_CYCLES=8)
REQ-036 Test: reset, then btn_raw=1 for 10 cycles -> exactly one step_pulse, sela=1.
REQ-037 Test: btn_raw glitches 1 for 2 cycles, 0, repeated 5 times -> no step_pulse, sela stays 0.
REQ-038 Test: 8 clean presses -> sela sequence 1,2,...,7,0 (wrap).
REQ-039 Test: auto_en=1 for 40 cycles -> step_pulse every 8 cycles, sela 1..5; a button press in this window -> no extra step.
REQ-040 Test: alu_a=32'hDEADBEEF, alu_b=32'h12345678, of_in=1, zf_in=0 with a cap_en pulse, then the sources change without cap_en -> dina=32'hDEADBEEF, dinb=32'h12345678, ofa=1, zfa=0 held.
REQ-041 Test: rst_n=0 during PRESS_WAIT, coincident with cap_en -> all outputs 0; no step after reset release.

Source files
------------

// File: rtl/led_sel_ctrl_if.sv
// rtl/led_sel_ctrl_if.sv - capture bus between the display sources and the LED select controller
interface led_sel_ctrl_if;
   logic        cap_en;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic        of_in;
   logic        zf_in;
   logic [31:0] dina;
   logic [31:0] dinb;
   logic        ofa;
   logic        zfa;

   // Source side: drives the live words and the capture strobe, observes the held copies
   modport master (
      output cap_en, alu_a, alu_b, of_in, zf_in,
      input  dina, dinb, ofa, zfa
   );

   // Controller side: samples the sources on cap_en and presents the held copies
   modport slave (
      input  cap_en, alu_a, alu_b, of_in, zf_in,
      output dina, dinb, ofa, zfa
   );
endinterface

// File: rtl/led_sel_ctrl.sv
// rtl/led_sel_ctrl.sv - debounced/auto-scan LED byte selector with display source capture
module led_sel_ctrl #(
   parameter logic [15:0] DB_CYCLES   = 16'd50000,
   parameter logic [25:0] SCAN_CYCLES = 26'd50000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_raw,
   input  logic             auto_en,
   led_sel_ctrl_if.slave    bus,
   output logic [2:0]       sela,
   output logic             step_pulse
);

   localparam logic [15:0] DB_LAST   = DB_CYCLES - 16'd1;
   localparam logic [25:0] SCAN_LAST = SCAN_CYCLES - 26'd1;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } db_state_t;

   logic        sync0;
   logic        sync1;
   logic        btn_s;
   db_state_t   state;
   db_state_t   state_nxt;
   logic [15:0] db_cnt;
   logic [15:0] db_cnt_nxt;
   logic        press_evt;
   logic [25:0] scan_cnt;
   logic        scan_wrap;
   logic        step;

   assign btn_s = sync1;

   // Two-flop synchronizer: btn_raw is asynchronous to clk
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync0 <= 1'b0;
         sync1 <= 1'b0;
      end else begin
         sync0 <= btn_raw;
         sync1 <= sync0;
      end
   end

   // Debouncer state and stability counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         db_cnt <= 16'd0;
      end else begin
         state  <= state_nxt;
         db_cnt <= db_cnt_nxt;
      end
   end

   // Debouncer next state; a press fires only on the PRESS_WAIT -> HELD transition
   always_comb begin
      state_nxt  = state;
      db_cnt_nxt = db_cnt;
      press_evt  = 1'b0;
      case (state)
         IDLE: begin
            if (btn_s) begin
               state_nxt  = PRESS_WAIT;
               db_cnt_nxt = 16'd0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_nxt = IDLE;
            end else if (db_cnt == DB_LAST) begin
               state_nxt = HELD;
               press_evt = 1'b1;
            end else begin
               db_cnt_nxt = db_cnt + 16'd1;
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_nxt  = RELEASE_WAIT;
               db_cnt_nxt = 16'd0;
            end
         end
         RELEASE_WAIT: begin
            if (btn_s) begin
               state_nxt = HELD;
            end else if (db_cnt == DB_LAST) begin
               state_nxt = IDLE;
            end else begin
               db_cnt_nxt = db_cnt + 16'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Scan counter runs only in auto mode so the first auto step is a full period after entry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt <= 26'd0;
      end else if (!auto_en) begin
         scan_cnt <= 26'd0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= 26'd0;
      end else begin
         scan_cnt <= scan_cnt + 26'd1;
      end
   end

   assign scan_wrap = auto_en && (scan_cnt == SCAN_LAST);
   assign step      = auto_en ? scan_wrap : press_evt;

   // Byte select advances (wrapping 7 -> 0) with a coincident one-cycle pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sela       <= 3'd0;
         step_pulse <= 1'b0;
      end else begin
         step_pulse <= step;
         if (step) begin
            sela <= sela + 3'd1;
         end
      end
   end

   // Display source capture, independent of stepping
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.dina <= 32'd0;
         bus.dinb <= 32'd0;
         bus.ofa  <= 1'b0;
         bus.zfa  <= 1'b0;
      end else if (bus.cap_en) begin
         bus.dina <= bus.alu_a;
         bus.dinb <= bus.alu_b;
         bus.ofa  <= bus.of_in;
         bus.zfa  <= bus.zf_in;
      end
   end

endmodule
